// File: rtl/data_island_packet_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_island_packet_scheduler_if
//  Description : Bundles the audio-sample handshake, the packet-slot strobes
//                and the packet-selection results of the data-island packet
//                scheduler.
//                Audio sample words are two 24-bit lanes: [0]=left, [1]=right.
//  Modports    : master - producer/consumer side (drives slot strobes and
//                         samples, observes packet selection)
//                slave  - scheduler side
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_island_packet_scheduler_if;
    logic              packet_enable;
    logic              video_field_end;
    logic              audio_sample_valid;
    logic              audio_sample_ready;
    logic [1:0][23:0]  audio_sample_word_in;
    logic [1:0][23:0]  audio_sample_word;
    logic [7:0]        packet_type;
    logic              sample_packet_enable;
    logic              acr_missed;

    modport master (
        output packet_enable, video_field_end, audio_sample_valid,
               audio_sample_word_in,
        input  audio_sample_ready, audio_sample_word, packet_type,
               sample_packet_enable, acr_missed
    );

    modport slave (
        input  packet_enable, video_field_end, audio_sample_valid,
               audio_sample_word_in,
        output audio_sample_ready, audio_sample_word, packet_type,
               sample_packet_enable, acr_missed
    );
endinterface
`default_nettype wire

// File: rtl/data_island_packet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : data_island_packet_scheduler
//  Description : Chooses the content of every HDMI data-island packet slot.
//                Strict priority: ACR > audio sample > AVI InfoFrame >
//                Audio InfoFrame > null. Audio samples are buffered in a
//                small FIFO; ACR requests come from a free-running timer;
//                InfoFrame requests are raised once per video field.
//  Ports       : clk_pixel - sole clock (rising edge)
//                reset     - synchronous active-high reset
//                bus       - scheduler side of data_island_packet_scheduler_if
//                            (slot strobes, sample handshake, packet outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_island_packet_scheduler #(
    parameter int ACR_INTERVAL = 1024,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic                    clk_pixel,
    input  wire logic                    reset,
    data_island_packet_scheduler_if.slave bus
);

    localparam int              TW         = $clog2(ACR_INTERVAL);
    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(ACR_INTERVAL - 1);
    localparam logic [PW:0]     FIFO_FULL  = (PW + 1)'(FIFO_DEPTH);

    localparam logic [7:0] TYPE_NULL   = 8'h00;
    localparam logic [7:0] TYPE_ACR    = 8'h01;
    localparam logic [7:0] TYPE_SAMPLE = 8'h02;
    localparam logic [7:0] TYPE_AVI    = 8'h82;
    localparam logic [7:0] TYPE_AIF    = 8'h84;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_NULL   = 3'd1,
        SEL_ACR    = 3'd2,
        SEL_SAMPLE = 3'd3,
        SEL_AVI    = 3'd4,
        SEL_AIF    = 3'd5
    } sel_t;

    logic [TW-1:0]     acr_timer;
    logic              acr_pending;
    logic              avi_pending;
    logic              aif_pending;
    logic              acr_missed_q;

    logic [1:0][23:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    logic [7:0]        packet_type_q;
    logic [1:0][23:0]  sample_word_q;
    logic              sample_pulse_q;

    sel_t              sel;
    logic [7:0]        sel_type;
    logic              timer_expire;
    logic              push;
    logic              pop;

    assign timer_expire = (acr_timer == TIMER_LAST);
    assign bus.audio_sample_ready = (count < FIFO_FULL) && !reset;
    assign push = bus.audio_sample_valid && bus.audio_sample_ready;
    assign pop  = (sel == SEL_SAMPLE);

    // Slot content decision; SEL_NONE means no slot this cycle.
    always_comb begin
        sel      = SEL_NONE;
        sel_type = TYPE_NULL;
        if (bus.packet_enable) begin
            if (acr_pending) begin
                sel      = SEL_ACR;
                sel_type = TYPE_ACR;
            end else if (count != '0) begin
                sel      = SEL_SAMPLE;
                sel_type = TYPE_SAMPLE;
            end else if (avi_pending) begin
                sel      = SEL_AVI;
                sel_type = TYPE_AVI;
            end else if (aif_pending) begin
                sel      = SEL_AIF;
                sel_type = TYPE_AIF;
            end else begin
                sel      = SEL_NULL;
                sel_type = TYPE_NULL;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.audio_sample_word_in;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acr_timer      <= '0;
            acr_pending    <= 1'b0;
            avi_pending    <= 1'b0;
            aif_pending    <= 1'b0;
            acr_missed_q   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            packet_type_q  <= TYPE_NULL;
            sample_word_q  <= '0;
            sample_pulse_q <= 1'b0;
        end else begin
            acr_timer <= timer_expire ? '0 : acr_timer + 1'b1;

            // A new request at the same edge as a service outranks the clear.
            acr_pending <= timer_expire || (acr_pending && (sel != SEL_ACR));
            avi_pending <= bus.video_field_end || (avi_pending && (sel != SEL_AVI));
            aif_pending <= bus.video_field_end || (aif_pending && (sel != SEL_AIF));

            // A request being serviced on this very edge is not a miss.
            if (timer_expire && acr_pending && (sel != SEL_ACR)) begin
                acr_missed_q <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (sel != SEL_NONE) begin
                packet_type_q <= sel_type;
            end
            if (pop) begin
                sample_word_q <= fifo_mem[rd_ptr];
            end
            sample_pulse_q <= pop;
        end
    end

    assign bus.packet_type          = packet_type_q;
    assign bus.audio_sample_word    = sample_word_q;
    assign bus.sample_packet_enable = sample_pulse_q;
    assign bus.acr_missed           = acr_missed_q;

endmodule
`default_nettype wire

// File: tb/tb_data_island_packet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_island_packet_scheduler
//  Description : Self-checking bench for data_island_packet_scheduler with
//                ACR_INTERVAL=64 and FIFO_DEPTH=4. A table of per-cycle
//                vectors covers selection priority, FIFO order/backpressure
//                and InfoFrame flag behaviour; hand-written sequences cover
//                ACR timing, the sticky miss flag and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_island_packet_scheduler;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;
    int   tests     = 0;
    int   fails     = 0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_scheduler_if bus ();

    data_island_packet_scheduler #(
        .ACR_INTERVAL (64),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        logic        pe;
        logic        vfe;
        logic        valid;
        logic [23:0] l;
        logic [23:0] r;
        logic [7:0]  typ;
        logic [23:0] wl;
        logic [23:0] wr;
        logic        spe;
        logic        rdy;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic pe, input logic vfe, input logic valid,
                     input logic [23:0] l, input logic [23:0] r,
                     input logic [7:0] typ, input logic [23:0] wl,
                     input logic [23:0] wr, input logic spe, input logic rdy);
        vec_t e;
        e.pe = pe; e.vfe = vfe; e.valid = valid; e.l = l; e.r = r;
        e.typ = typ; e.wl = wl; e.wr = wr; e.spe = spe; e.rdy = rdy;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic step(input logic pe, input logic vfe, input logic valid,
                        input logic [23:0] l, input logic [23:0] r);
        @(negedge clk_pixel);
        bus.packet_enable           = pe;
        bus.video_field_end         = vfe;
        bus.audio_sample_valid      = valid;
        bus.audio_sample_word_in[0] = l;
        bus.audio_sample_word_in[1] = r;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic idle();
        step(N, N, N, 24'h0, 24'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_pixel);
        reset                    = 1'b1;
        bus.packet_enable        = 1'b0;
        bus.video_field_end      = 1'b0;
        bus.audio_sample_valid   = 1'b0;
        bus.audio_sample_word_in = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        chk({tag, " rst type"},  {40'h0, bus.packet_type}, 48'h0);
        chk({tag, " rst word"},  bus.audio_sample_word, 48'h0);
        chk({tag, " rst spe"},   {47'h0, bus.sample_packet_enable}, 48'h0);
        chk({tag, " rst ready"}, {47'h0, bus.audio_sample_ready}, 48'h0);
        chk({tag, " rst miss"},  {47'h0, bus.acr_missed}, 48'h0);
        reset = 1'b0;
    endtask

    initial begin
        bus.packet_enable        = 1'b0;
        bus.video_field_end      = 1'b0;
        bus.audio_sample_valid   = 1'b0;
        bus.audio_sample_word_in = '0;

        //  pe vfe val  L        R        | type   wordL    wordR   spe rdy
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h0,  24'h0,  N, Y);  // 0 null slot
        v(N, N, N, 24'h0,  24'h0,  8'h00, 24'h0,  24'h0,  N, Y);
        v(N, N, Y, 24'h1,  24'h2,  8'h00, 24'h0,  24'h0,  N, Y);
        v(N, N, Y, 24'h3,  24'h4,  8'h00, 24'h0,  24'h0,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h1,  24'h2,  Y, Y);  // 4 first sample
        v(N, N, N, 24'h0,  24'h0,  8'h02, 24'h1,  24'h2,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h3,  24'h4,  Y, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);  // 7 word held
        v(N, Y, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);  // 8 field end
        v(Y, N, N, 24'h0,  24'h0,  8'h82, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h84, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);
        v(Y, Y, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);  // 12 decided before flag
        v(Y, N, N, 24'h0,  24'h0,  8'h82, 24'h3,  24'h4,  N, Y);
        v(Y, Y, N, 24'h0,  24'h0,  8'h84, 24'h3,  24'h4,  N, Y);  // 14 aif set wins
        v(Y, N, N, 24'h0,  24'h0,  8'h82, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h84, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);
        v(N, Y, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);
        v(Y, Y, N, 24'h0,  24'h0,  8'h82, 24'h3,  24'h4,  N, Y);  // 19 avi set wins
        v(Y, N, N, 24'h0,  24'h0,  8'h82, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h84, 24'h3,  24'h4,  N, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h3,  24'h4,  N, Y);
        v(N, N, Y, 24'h10, 24'h20, 8'h00, 24'h3,  24'h4,  N, Y);  // 23 fill
        v(N, N, Y, 24'h11, 24'h21, 8'h00, 24'h3,  24'h4,  N, Y);
        v(N, N, Y, 24'h12, 24'h22, 8'h00, 24'h3,  24'h4,  N, Y);
        v(N, N, Y, 24'h13, 24'h23, 8'h00, 24'h3,  24'h4,  N, N);  // 26 full
        v(N, N, Y, 24'h14, 24'h24, 8'h00, 24'h3,  24'h4,  N, N);  // 27 refused
        v(Y, N, Y, 24'h14, 24'h24, 8'h02, 24'h10, 24'h20, Y, Y);  // 28 pop frees slot
        v(N, N, Y, 24'h14, 24'h24, 8'h02, 24'h10, 24'h20, N, N);  // 29 5th accepted
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h11, 24'h21, Y, Y);
        v(Y, N, Y, 24'h15, 24'h25, 8'h02, 24'h12, 24'h22, Y, Y);  // 31 push+pop
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h13, 24'h23, Y, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h14, 24'h24, Y, Y);
        v(Y, N, N, 24'h0,  24'h0,  8'h02, 24'h15, 24'h25, Y, Y);  // 34 wrapped ptrs
        v(Y, N, N, 24'h0,  24'h0,  8'h00, 24'h15, 24'h25, N, Y);  // 35 empty

        do_reset("init");
        foreach (vq[i]) begin
            step(vq[i].pe, vq[i].vfe, vq[i].valid, vq[i].l, vq[i].r);
            chk($sformatf("vec%0d type", i),  {40'h0, bus.packet_type}, {40'h0, vq[i].typ});
            chk($sformatf("vec%0d word", i),  bus.audio_sample_word, {vq[i].wr, vq[i].wl});
            chk($sformatf("vec%0d spe", i),   {47'h0, bus.sample_packet_enable}, {47'h0, vq[i].spe});
            chk($sformatf("vec%0d ready", i), {47'h0, bus.audio_sample_ready}, {47'h0, vq[i].rdy});
            chk($sformatf("vec%0d miss", i),  {47'h0, bus.acr_missed}, 48'h0);
        end

        // ACR outranks a waiting sample on the slot at cycle 64.
        do_reset("acr");
        step(N, N, Y, 24'hA, 24'hB);
        for (int i = 1; i <= 63; i++) idle();
        chk("acr pre type", {40'h0, bus.packet_type}, 48'h0);
        step(Y, N, N, 24'h0, 24'h0);
        chk("acr slot type", {40'h0, bus.packet_type}, 48'h01);
        chk("acr slot spe",  {47'h0, bus.sample_packet_enable}, 48'h0);
        step(Y, N, N, 24'h0, 24'h0);
        chk("acr next type", {40'h0, bus.packet_type}, 48'h02);
        chk("acr next word", bus.audio_sample_word, {24'hB, 24'hA});
        chk("acr next spe",  {47'h0, bus.sample_packet_enable}, 48'h1);
        step(Y, N, N, 24'h0, 24'h0);
        chk("acr last type", {40'h0, bus.packet_type}, 48'h00);
        chk("acr miss",      {47'h0, bus.acr_missed}, 48'h0);

        // Second expiry with the first still pending raises the sticky flag.
        do_reset("miss");
        for (int i = 0; i <= 126; i++) idle();
        chk("miss before 128", {47'h0, bus.acr_missed}, 48'h0);
        idle();
        chk("miss at 128", {47'h0, bus.acr_missed}, 48'h1);
        idle();
        idle();
        step(Y, N, N, 24'h0, 24'h0);
        chk("miss slot acr", {40'h0, bus.packet_type}, 48'h01);
        step(Y, N, N, 24'h0, 24'h0);
        chk("miss slot null", {40'h0, bus.packet_type}, 48'h00);
        chk("miss sticky", {47'h0, bus.acr_missed}, 48'h1);

        // Reset with buffered samples and pending InfoFrames discards them.
        step(N, N, Y, 24'h55, 24'h66);
        step(Y, N, N, 24'h0, 24'h0);
        chk("pre-rst word", bus.audio_sample_word, {24'h66, 24'h55});
        step(N, Y, Y, 24'h77, 24'h88);
        do_reset("mid");
        step(Y, N, N, 24'h0, 24'h0);
        chk("post-rst slot", {40'h0, bus.packet_type}, 48'h00);
        chk("post-rst spe",  {47'h0, bus.sample_packet_enable}, 48'h0);
        step(Y, N, N, 24'h0, 24'h0);
        chk("post-rst slot2", {40'h0, bus.packet_type}, 48'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
